// File: rtl/dsi_clk_lane_if.sv
// Clock-lane sequencer handshake and pad-control bundle.
interface dsi_clk_lane_if;
  logic enable;
  logic hs_req;
  logic hs_ready;
  logic clk_lp_p;
  logic clk_lp_n;
  logic clk_hs_oe;
  logic clk_hs_toggle;
  logic busy;

  modport master (
    output enable, hs_req,
    input  hs_ready, clk_lp_p, clk_lp_n, clk_hs_oe, clk_hs_toggle, busy
  );

  modport slave (
    input  enable, hs_req,
    output hs_ready, clk_lp_p, clk_lp_n, clk_hs_oe, clk_hs_toggle, busy
  );
endinterface

// File: rtl/dsi_clk_lane_sequencer.sv
// D-PHY clock-lane LP-11 -> HS -> LP-11 sequencer with hs_ready grant to the data lanes.
// Optional continuous-clock mode: define DSI_CLK_LANE_CONTINUOUS_EN.
module dsi_clk_lane_sequencer #(
  parameter int unsigned LPX_CYC         = 4,
  parameter int unsigned CLK_PREPARE_CYC = 4,
  parameter int unsigned CLK_ZERO_CYC    = 20,
  parameter int unsigned CLK_PRE_CYC     = 2,
  parameter int unsigned CLK_POST_CYC    = 8,
  parameter int unsigned CLK_TRAIL_CYC   = 5,
  parameter int unsigned HS_EXIT_CYC     = 8,
  parameter int unsigned CNT_W           = 8
) (
  input logic           clk,
  input logic           rst,
  dsi_clk_lane_if.slave lane
);

  typedef enum logic [2:0] {IDLE, LP01, LP00, ZERO, PRE, ACTIVE, POST, TRAIL} state_t;

  // Counter load value for an N-cycle state; N = 0 behaves as 1.
  function automatic logic [CNT_W-1:0] ld(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  localparam logic [CNT_W-1:0] LPX_LD   = ld(LPX_CYC);
  localparam logic [CNT_W-1:0] PREP_LD  = ld(CLK_PREPARE_CYC);
  localparam logic [CNT_W-1:0] ZERO_LD  = ld(CLK_ZERO_CYC);
  localparam logic [CNT_W-1:0] PRE_LD   = ld(CLK_PRE_CYC);
  localparam logic [CNT_W-1:0] POST_LD  = ld(CLK_POST_CYC);
  localparam logic [CNT_W-1:0] TRAIL_LD = ld(CLK_TRAIL_CYC);
  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(HS_EXIT_CYC);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] holdoff, holdoff_nx;
  logic             exit_req;
  logic [4:0]       out_nx;
  logic             busy_nx;
  logic             lp_p_q, lp_n_q, hs_oe_q, toggle_q, ready_q, busy_q;

`ifdef DSI_CLK_LANE_CONTINUOUS_EN
  logic hs_req_q;
  assign exit_req = !lane.enable;
`else
  assign exit_req = !lane.hs_req | !lane.enable;
`endif

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    holdoff_nx = holdoff;
    case (state)
      IDLE: begin
        if (holdoff != '0) holdoff_nx = holdoff - 1'b1;
        if (lane.enable && lane.hs_req && holdoff == '0) begin
          state_nx = LP01;
          cnt_nx   = LPX_LD;
        end
      end
      LP01:
        if (cnt == '0) begin state_nx = LP00; cnt_nx = PREP_LD; end
        else cnt_nx = cnt - 1'b1;
      LP00:
        if (cnt == '0) begin state_nx = ZERO; cnt_nx = ZERO_LD; end
        else cnt_nx = cnt - 1'b1;
      ZERO:
        if (cnt == '0) begin state_nx = PRE; cnt_nx = PRE_LD; end
        else cnt_nx = cnt - 1'b1;
      PRE:
        if (cnt == '0) begin state_nx = ACTIVE; cnt_nx = '0; end
        else cnt_nx = cnt - 1'b1;
      ACTIVE:
        if (exit_req) begin state_nx = POST; cnt_nx = POST_LD; end
      POST:
        if (cnt == '0) begin state_nx = TRAIL; cnt_nx = TRAIL_LD; end
        else cnt_nx = cnt - 1'b1;
      TRAIL:
        if (cnt == '0) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          holdoff_nx = EXIT_LD;
        end else cnt_nx = cnt - 1'b1;
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    out_nx = 5'b11000;
    case (state_nx)
      IDLE:    out_nx = 5'b11000;
      LP01:    out_nx = 5'b01000;
      LP00:    out_nx = 5'b00000;
      ZERO:    out_nx = 5'b00100;
      PRE:     out_nx = 5'b00110;
      ACTIVE:  out_nx = 5'b00111;
      POST:    out_nx = 5'b00110;
      TRAIL:   out_nx = 5'b00100;
      default: out_nx = 5'b11000;
    endcase
    busy_nx = !(state_nx == IDLE && holdoff_nx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      holdoff  <= '0;
      lp_p_q   <= 1'b1;
      lp_n_q   <= 1'b1;
      hs_oe_q  <= 1'b0;
      toggle_q <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      holdoff  <= holdoff_nx;
      {lp_p_q, lp_n_q, hs_oe_q, toggle_q, ready_q} <= out_nx;
      busy_q   <= busy_nx;
    end
  end

  assign lane.clk_lp_p      = lp_p_q;
  assign lane.clk_lp_n      = lp_n_q;
  assign lane.clk_hs_oe     = hs_oe_q;
  assign lane.clk_hs_toggle = toggle_q;
  assign lane.busy          = busy_q;

`ifdef DSI_CLK_LANE_CONTINUOUS_EN
  // Clock keeps running in ACTIVE; the grant tracks the request one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hs_req_q <= 1'b0;
    else     hs_req_q <= lane.hs_req;
  end
  assign lane.hs_ready = ready_q & hs_req_q;
`else
  assign lane.hs_ready = ready_q;
`endif

endmodule

// File: tb/tb_dsi_clk_lane_sequencer.sv
// Directed bench for dsi_clk_lane_sequencer with default timing parameters.
module tb_dsi_clk_lane_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dsi_clk_lane_if lane_if ();

  dsi_clk_lane_sequencer dut (
    .clk  (clk),
    .rst  (rst),
    .lane (lane_if)
  );

  always #5 clk = ~clk;

  // Expected vector order: {lp_p, lp_n, hs_oe, toggle, hs_ready, busy}
  typedef struct {
    int unsigned n;
    logic        en;
    logic        req;
    logic [5:0]  exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] outs();
    return {lane_if.clk_lp_p, lane_if.clk_lp_n, lane_if.clk_hs_oe,
            lane_if.clk_hs_toggle, lane_if.hs_ready, lane_if.busy};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string name);
    int unsigned cnt;
    cnt = 0;
    do begin
      tick(1);
      cnt++;
    end while (!lane_if.hs_ready && cnt < 200);
    checks++;
    if (cnt != 31) begin
      errors++;
      $display("FAIL %s: got %0d edges expected 31", name, cnt);
    end
  endtask

  initial begin
    lane_if.enable = 1'b0;
    lane_if.hs_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", 6'b110000);

`ifndef DSI_CLK_LANE_CONTINUOUS_EN
    // Cycle c is observed just after edge c-1; entry request sampled at edge 0.
    tbl.push_back('{1,  1'b1, 1'b1, 6'b010001});  // 1   LP01
    tbl.push_back('{3,  1'b1, 1'b1, 6'b010001});  // 4
    tbl.push_back('{1,  1'b1, 1'b1, 6'b000001});  // 5   LP00
    tbl.push_back('{3,  1'b1, 1'b1, 6'b000001});  // 8
    tbl.push_back('{1,  1'b1, 1'b1, 6'b001001});  // 9   ZERO
    tbl.push_back('{19, 1'b1, 1'b1, 6'b001001});  // 28
    tbl.push_back('{1,  1'b1, 1'b1, 6'b001101});  // 29  PRE
    tbl.push_back('{1,  1'b1, 1'b1, 6'b001101});  // 30
    tbl.push_back('{1,  1'b1, 1'b1, 6'b001111});  // 31  ACTIVE
    tbl.push_back('{69, 1'b1, 1'b1, 6'b001111});  // 100
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001101});  // 101 POST
    tbl.push_back('{7,  1'b1, 1'b0, 6'b001101});  // 108
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001001});  // 109 TRAIL
    tbl.push_back('{4,  1'b1, 1'b0, 6'b001001});  // 113
    tbl.push_back('{1,  1'b1, 1'b0, 6'b110001});  // 114 IDLE, hold-off
    tbl.push_back('{1,  1'b1, 1'b0, 6'b110001});  // 115
    tbl.push_back('{1,  1'b1, 1'b1, 6'b110001});  // 116 request held off
    tbl.push_back('{5,  1'b1, 1'b1, 6'b110001});  // 121
    tbl.push_back('{1,  1'b1, 1'b1, 6'b110000});  // 122 busy low
    tbl.push_back('{1,  1'b1, 1'b1, 6'b010001});  // 123 LP01
    tbl.push_back('{29, 1'b1, 1'b0, 6'b001101});  // 152 PRE, entry not aborted
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001111});  // 153 single ready cycle
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001101});  // 154 POST
    tbl.push_back('{7,  1'b1, 1'b0, 6'b001101});  // 161
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001001});  // 162 TRAIL
    tbl.push_back('{4,  1'b1, 1'b0, 6'b001001});  // 166
    tbl.push_back('{1,  1'b1, 1'b0, 6'b110001});  // 167
    tbl.push_back('{8,  1'b1, 1'b0, 6'b110000});  // 175
    tbl.push_back('{1,  1'b1, 1'b1, 6'b010001});  // 176 one-cycle pulse
    tbl.push_back('{29, 1'b1, 1'b0, 6'b001101});  // 205 PRE
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001111});  // 206 ACTIVE
    tbl.push_back('{1,  1'b1, 1'b0, 6'b001101});  // 207 POST

    foreach (tbl[i]) begin
      lane_if.enable = tbl[i].en;
      lane_if.hs_req = tbl[i].req;
      tick(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
`endif

    // Async reset from ZERO, then fresh entry latency.
    lane_if.enable = 1'b1;
    lane_if.hs_req = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick(15);
    check("in_zero", 6'b001001);
    #2 rst = 1'b1;
    #1 check("rst_from_zero", 6'b110000);
    #2 rst = 1'b0;
    latency_check("latency_after_zero_rst");
    check("active_after_rst", 6'b001111);

    // Async reset from ACTIVE: no exit sequence.
    #2 rst = 1'b1;
    #1 check("rst_from_active", 6'b110000);
    #2 rst = 1'b0;
    latency_check("latency_after_active_rst");

`ifdef DSI_CLK_LANE_CONTINUOUS_EN
    lane_if.hs_req = 1'b0;
    tick(1);
    check("cont_req_low", 6'b001101);
    tick(1);
    check("cont_req_low_hold", 6'b001101);
    lane_if.hs_req = 1'b1;
    tick(1);
    check("cont_req_high", 6'b001111);
`endif

    // enable low exits through POST/TRAIL even with hs_req held.
    lane_if.enable = 1'b0;
    tick(1);
    check("en_exit_post", 6'b001101);
    tick(7);
    check("en_exit_post_end", 6'b001101);
    tick(1);
    check("en_exit_trail", 6'b001001);
    tick(5);
    check("en_exit_lp11", 6'b110001);
    tick(8);
    check("en_exit_idle", 6'b110000);
    tick(3);
    check("en_low_no_entry", 6'b110000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
